// File: rtl/dut.sv
// Register-file command stage: accepts one command per cycle, updates a small
// register file on WRITE, returns stored data on READ and forwards the command
// downstream with a fixed one-cycle latency. Master outputs feed the slave
// inputs of an identical instance directly, so stages can be chained.
module dut #(
    parameter int unsigned CMD_W  = 2,
    parameter int unsigned ADR_W  = 2,
    parameter int unsigned DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  s_cmd,
    input  logic [ADR_W-1:0]  s_adr,
    input  logic [DATA_W-1:0] s_data,
    output logic [CMD_W-1:0]  m_cmd,
    output logic [ADR_W-1:0]  m_adr,
    output logic [DATA_W-1:0] m_data,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       err_cnt
);

    localparam int unsigned Depth = 2 ** ADR_W;

    localparam logic [CMD_W-1:0] CmdNop   = CMD_W'(0);
    localparam logic [CMD_W-1:0] CmdWrite = CMD_W'(1);
    localparam logic [CMD_W-1:0] CmdRead  = CMD_W'(2);

    logic [DATA_W-1:0] regfile_q [Depth];

    logic [CMD_W-1:0]  m_cmd_d;
    logic [ADR_W-1:0]  m_adr_d;
    logic [DATA_W-1:0] m_data_d;
    logic [15:0]       wr_cnt_d;
    logic [15:0]       err_cnt_d;
    logic              is_write;
    logic              is_rsvd;

    // Decode the incoming command into next-state outputs and counter updates.
    always_comb begin
        m_cmd_d   = CmdNop;
        m_adr_d   = '0;
        m_data_d  = '0;
        is_write  = 1'b0;
        is_rsvd   = 1'b0;
        case (s_cmd)
            CmdNop: begin
                is_rsvd = 1'b0;
            end
            CmdWrite: begin
                is_write = 1'b1;
                m_cmd_d  = CmdWrite;
                m_adr_d  = s_adr;
                m_data_d = s_data;
            end
            CmdRead: begin
                // Register file read returns the pre-edge contents; a WRITE on
                // the previous cycle has already landed, so no bypass is needed.
                m_cmd_d  = CmdRead;
                m_adr_d  = s_adr;
                m_data_d = regfile_q[s_adr];
            end
            default: begin
                is_rsvd = 1'b1;
            end
        endcase

        // Counters stick at all-ones instead of wrapping.
        wr_cnt_d  = (is_write && (wr_cnt != 16'hFFFF)) ? wr_cnt + 16'd1 : wr_cnt;
        err_cnt_d = (is_rsvd && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    end

    // Register outputs and counters; reset wins over any command in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_cmd   <= '0;
            m_adr   <= '0;
            m_data  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            m_cmd   <= m_cmd_d;
            m_adr   <= m_adr_d;
            m_data  <= m_data_d;
            wr_cnt  <= wr_cnt_d;
            err_cnt <= err_cnt_d;
        end
    end

    // Register file storage: cleared on reset, written by accepted WRITEs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                regfile_q[i] <= '0;
            end
        end else if (is_write) begin
            regfile_q[s_adr] <= s_data;
        end
    end

endmodule

// File: tb/tb_dut.sv
// Bench for three chained dut stages: randomized and directed stimulus, a
// queue-based scoreboard fed by a reference model, and a decoupled monitor.
module tb_dut;

    logic       clk;
    logic       rst;
    logic [1:0] s_cmd;
    logic [1:0] s_adr;
    logic [2:0] s_data;

    logic [1:0]  mc [3];
    logic [1:0]  ma [3];
    logic [2:0]  md [3];
    logic [15:0] wc [3];
    logic [15:0] ec [3];

    int n_checks = 0;
    int n_errors = 0;

    dut u0 (
        .clk(clk), .rst(rst),
        .s_cmd(s_cmd), .s_adr(s_adr), .s_data(s_data),
        .m_cmd(mc[0]), .m_adr(ma[0]), .m_data(md[0]),
        .wr_cnt(wc[0]), .err_cnt(ec[0])
    );

    dut u1 (
        .clk(clk), .rst(rst),
        .s_cmd(mc[0]), .s_adr(ma[0]), .s_data(md[0]),
        .m_cmd(mc[1]), .m_adr(ma[1]), .m_data(md[1]),
        .wr_cnt(wc[1]), .err_cnt(ec[1])
    );

    dut u2 (
        .clk(clk), .rst(rst),
        .s_cmd(mc[1]), .s_adr(ma[1]), .s_data(md[1]),
        .m_cmd(mc[2]), .m_adr(ma[2]), .m_data(md[2]),
        .wr_cnt(wc[2]), .err_cnt(ec[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-stage register file, outputs and counters as ints.
    typedef struct {
        int cmd;
        int adr;
        int data;
        int wr;
        int er;
    } exp_t;

    int   rf [3][4];
    exp_t cur [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    task automatic model_step(input bit r, input int c, input int a, input int d);
        int ic [3];
        int ia [3];
        int id [3];
        ic[0] = c; ia[0] = a; id[0] = d;
        for (int k = 1; k < 3; k++) begin
            ic[k] = cur[k-1].cmd;
            ia[k] = cur[k-1].adr;
            id[k] = cur[k-1].data;
        end
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                cur[k] = '{0, 0, 0, 0, 0};
                for (int j = 0; j < 4; j++) rf[k][j] = 0;
            end else begin
                cur[k].cmd = 0; cur[k].adr = 0; cur[k].data = 0;
                if (ic[k] == 1) begin
                    rf[k][ia[k]] = id[k];
                    cur[k].cmd = 1; cur[k].adr = ia[k]; cur[k].data = id[k];
                    if (cur[k].wr < 65535) cur[k].wr++;
                end else if (ic[k] == 2) begin
                    cur[k].cmd = 2; cur[k].adr = ia[k]; cur[k].data = rf[k][ia[k]];
                end else if (ic[k] == 3) begin
                    if (cur[k].er < 65535) cur[k].er++;
                end
            end
        end
        q0.push_back(cur[0]);
        q1.push_back(cur[1]);
        q2.push_back(cur[2]);
    endtask

    // Apply one command (or reset) for the next rising edge and record the expectation.
    task automatic drive(input bit r, input int c, input int a, input int d);
        @(negedge clk);
        rst    = r;
        s_cmd  = 2'(c);
        s_adr  = 2'(a);
        s_data = 3'(d);
        model_step(r, c, a, d);
    endtask

    task automatic cmp_stage(input int k, input exp_t e);
        int ac, aa, ad, aw, ae;
        ac = int'(mc[k]); aa = int'(ma[k]); ad = int'(md[k]);
        aw = int'(wc[k]); ae = int'(ec[k]);
        n_checks++;
        if (ac != e.cmd || aa != e.adr || ad != e.data || aw != e.wr || ae != e.er) begin
            n_errors++;
            $display("FAIL scoreboard stage%0d @%0t: got cmd=%0d adr=%0d data=%0d wr=%0d err=%0d, expected cmd=%0d adr=%0d data=%0d wr=%0d err=%0d",
                     k, $time, ac, aa, ad, aw, ae, e.cmd, e.adr, e.data, e.wr, e.er);
        end
    endtask

    // Monitor: after each rising edge, pop one expectation per stage and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) cmp_stage(0, q0.pop_front());
            if (q1.size() > 0) cmp_stage(1, q1.pop_front());
            if (q2.size() > 0) cmp_stage(2, q2.pop_front());
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait until just after the edge that consumed the last driven command.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int st_adr [100];
    int st_dat [100];

    initial begin
        rst = 1'b1; s_cmd = '0; s_adr = '0; s_data = '0;

        // Reset state.
        drive(1, 0, 0, 0);
        drive(1, 1, 3, 7);
        after_edge();
        for (int k = 0; k < 3; k++) begin
            chk("reset m_cmd", int'(mc[k]), 0);
            chk("reset m_data", int'(md[k]), 0);
            chk("reset wr_cnt", int'(wc[k]), 0);
        end

        // Simple write pass-through.
        drive(0, 1, 1, 5);
        after_edge();
        chk("write m_cmd", int'(mc[0]), 1);
        chk("write m_adr", int'(ma[0]), 1);
        chk("write m_data", int'(md[0]), 5);
        chk("write wr_cnt", int'(wc[0]), 1);

        // Back-to-back write then read of the same address.
        drive(0, 1, 2, 7);
        drive(0, 2, 2, 0);
        after_edge();
        chk("wr->rd m_cmd", int'(mc[0]), 2);
        chk("wr->rd m_adr", int'(ma[0]), 2);
        chk("wr->rd m_data", int'(md[0]), 7);

        // Read after reset, then reserved command.
        drive(1, 0, 0, 0);
        drive(0, 2, 3, 4);
        after_edge();
        chk("rd after rst m_data", int'(md[0]), 0);
        chk("rd after rst m_adr", int'(ma[0]), 3);
        drive(0, 3, 2, 6);
        after_edge();
        chk("reserved m_cmd", int'(mc[0]), 0);
        chk("reserved m_adr", int'(ma[0]), 0);
        chk("reserved err_cnt", int'(ec[0]), 1);

        // Write in a reset cycle must be discarded.
        drive(1, 1, 1, 6);
        drive(0, 2, 1, 0);
        after_edge();
        chk("rst-write m_data", int'(md[0]), 0);
        chk("rst-write wr_cnt", int'(wc[0]), 0);

        // Chain: 100 writes, final stage lags the input by three edges.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            st_adr[i] = int'($urandom_range(1, 2));
            st_dat[i] = int'($urandom_range(0, 7));
            drive(0, 1, st_adr[i], st_dat[i]);
            after_edge();
            if (i >= 2) begin
                chk("chain m_cmd", int'(mc[2]), 1);
                chk("chain m_adr", int'(ma[2]), st_adr[i-2]);
                chk("chain m_data", int'(md[2]), st_dat[i-2]);
            end
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        after_edge();
        for (int k = 0; k < 3; k++) chk("chain wr_cnt", int'(wc[k]), 100);

        // Randomized mixed traffic with occasional mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 29) == 0),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)));
        end

        // Write counter saturation.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 65534; i++) begin
            drive(0, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end
        after_edge();
        chk("sat pre wr_cnt", int'(wc[0]), 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, i, i);
            after_edge();
            chk("sat wr_cnt", int'(wc[0]), 16'hFFFF);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        after_edge();
        for (int k = 0; k < 3; k++) chk("sat hold wr_cnt", int'(wc[k]), 16'hFFFF);

        after_edge();
        chk("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
